// File: rtl/serdes_if.sv
// serdes_if: parallel-side bundle of the serdes_loopback link model.
//   master  : producer/consumer side (drives parallel_in, valid_in)
//   slave   : serdes_loopback side (drives ready_out, parallel_out,
//             valid_out, fifo_full, fifo_empty)
interface serdes_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] parallel_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] parallel_out;
    logic                  valid_out;
    logic                  fifo_full;
    logic                  fifo_empty;

    modport master (
        output parallel_in, valid_in,
        input  ready_out, parallel_out, valid_out, fifo_full, fifo_empty
    );

    modport slave (
        input  parallel_in, valid_in,
        output ready_out, parallel_out, valid_out, fifo_full, fifo_empty
    );
endinterface

// File: rtl/serdes_loopback.sv
// serdes_loopback: parallel words in on a valid/ready handshake, optional
// first-word-fall-through FIFO, serializer onto a one-bit internal line
// (LSB first), deserializer back to a parallel word with a one-cycle strobe.
//   clk, rst_n        : clock, asynchronous active-low reset
//   link.parallel_in  : input word         link.valid_in  : input valid
//   link.ready_out    : block can take a word
//   link.parallel_out : reconstructed word link.valid_out : one-cycle strobe
//   link.fifo_full    : FIFO holds FIFO_DEPTH words (0 in bypass)
//   link.fifo_empty   : FIFO holds no words (0 in bypass)
//
// Serializer FSM
//   state   | meaning
//   S_IDLE  | ready for a word, serial line and enable low
//   S_SHIFT | driving bit ser_cnt of the captured word onto the line
module serdes_loopback #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    serdes_if.slave  link
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

    ser_state_t            state, state_nxt;
    logic                  ser_ready, ser_valid, ser_accept;
    logic                  ser_bit, ser_en, ser_start;
    logic [DATA_WIDTH-1:0] ser_data, ser_shreg;
    logic [CNT_W-1:0]      ser_cnt;

    logic [DATA_WIDTH-1:0] des_word, des_next, par_q;
    logic [CNT_W-1:0]      des_cnt, des_idx;
    logic                  valid_q;

    logic                  ready_w, full_w, empty_w;

    // ---------------- source: bypass or FIFO ----------------
    if (FIFO_DEPTH == 0) begin : g_bypass
        assign ser_valid = link.valid_in;
        assign ser_data  = link.parallel_in;
        assign ready_w   = ser_ready;
        assign full_w    = 1'b0;
        assign empty_w   = 1'b0;
    end else begin : g_fifo
        localparam int               PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
        localparam int               OCC_W    = $clog2(FIFO_DEPTH + 1);
        localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
        localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
        localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);
        localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr, rd_ptr;
        logic [OCC_W-1:0]      occ;
        logic                  full, empty, push, pop;

        assign full  = (occ == FULL_OCC);
        assign empty = (occ == '0);
        assign push  = link.valid_in & ~full;
        // One pop per serializer accept; the serializer only sees valid
        // when the FIFO holds a word, so an empty FIFO is never popped.
        assign pop   = ser_ready & ~empty;

        assign ser_valid = ~empty;
        assign ser_data  = mem[rd_ptr];
        assign ready_w   = ~full;
        assign full_w    = full;
        assign empty_w   = empty;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
            end else begin
                if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_ONE;
                case ({push, pop})
                    2'b10:   occ <= occ + OCC_ONE;
                    2'b01:   occ <= occ - OCC_ONE;
                    default: occ <= occ;
                endcase
            end
        end

        // Storage needs no reset: occupancy gates every read.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= link.parallel_in;
        end
    end

    // ---------------- serializer ----------------
    assign ser_accept = ser_ready & ser_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ser_ready = 1'b0;
        ser_en    = 1'b0;
        ser_start = 1'b0;
        ser_bit   = 1'b0;
        case (state)
            S_IDLE: begin
                ser_ready = 1'b1;
                if (ser_valid) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                ser_en    = 1'b1;
                ser_start = (ser_cnt == '0);
                ser_bit   = ser_shreg[0];
                if (ser_cnt == LAST_BIT) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_shreg <= '0;
            ser_cnt   <= '0;
        end else if (ser_accept) begin
            ser_shreg <= ser_data;
            ser_cnt   <= '0;
        end else if (ser_en) begin
            ser_shreg <= ser_shreg >> 1;
            ser_cnt   <= ser_cnt + CNT_ONE;
        end
    end

    // ---------------- deserializer ----------------
    // start forces bit position 0 so a stale count can never misalign a word.
    always_comb begin
        des_idx           = ser_start ? '0 : des_cnt;
        des_next          = des_word;
        des_next[des_idx] = ser_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            des_word <= '0;
            des_cnt  <= '0;
            par_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (ser_en) begin
                des_word <= des_next;
                des_cnt  <= des_idx + CNT_ONE;
                if (des_idx == LAST_BIT) begin
                    par_q   <= des_next;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign link.ready_out    = ready_w;
    assign link.parallel_out = par_q;
    assign link.valid_out    = valid_q;
    assign link.fifo_full    = full_w;
    assign link.fifo_empty   = empty_w;
endmodule

// File: tb/tb_serdes_loopback.sv
// Directed bench for serdes_loopback: one bypass instance (FIFO_DEPTH=0)
// and one FIFO instance (FIFO_DEPTH=4), W=8, sharing clock and reset.
module tb_serdes_loopback;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serdes_if #(.DATA_WIDTH(8)) if_b ();
    serdes_if #(.DATA_WIDTH(8)) if_f ();

    serdes_loopback #(.DATA_WIDTH(8), .FIFO_DEPTH(0)) u_byp (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (if_b)
    );

    serdes_loopback #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (if_f)
    );

    logic [7:0] obs_b [$];
    int         obs_bc [$];
    logic [7:0] obs_f [$];
    int         obs_fc [$];

    always @(negedge clk) begin
        if (rst_n && if_b.valid_out) begin
            obs_b.push_back(if_b.parallel_out);
            obs_bc.push_back(cyc);
        end
        if (rst_n && if_f.valid_out) begin
            obs_f.push_back(if_f.parallel_out);
            obs_fc.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] sw [4];
    logic [7:0] fw [6];
    int         acc_k [6];
    int         idx, k, c0;
    logic       acc;

    initial begin
        sw = '{8'h01, 8'h80, 8'hFF, 8'h00};
        fw = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        if_b.parallel_in = '0; if_b.valid_in = 1'b0;
        if_f.parallel_in = '0; if_f.valid_in = 1'b0;

        // ---------- reset values ----------
        repeat (3) @(negedge clk);
        check_val("rst_b_valid", if_b.valid_out, 0);
        check_val("rst_b_pout", if_b.parallel_out, 0);
        check_val("rst_b_ready", if_b.ready_out, 1);
        check_val("rst_b_empty", if_b.fifo_empty, 0);
        check_val("rst_b_full", if_b.fifo_full, 0);
        check_val("rst_f_valid", if_f.valid_out, 0);
        check_val("rst_f_pout", if_f.parallel_out, 0);
        check_val("rst_f_ready", if_f.ready_out, 1);
        check_val("rst_f_empty", if_f.fifo_empty, 1);
        check_val("rst_f_full", if_f.fifo_full, 0);
        check_val("rst_f_line", u_fifo.ser_bit, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------- bypass single word ----------
        if_b.parallel_in = 8'hA5;
        if_b.valid_in    = 1'b1;
        @(posedge clk);
        #1 if_b.valid_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check_val($sformatf("byp_ready_c%0d", i), if_b.ready_out, (i >= 9) ? 1 : 0);
            check_val($sformatf("byp_valid_c%0d", i), if_b.valid_out, (i == 9) ? 1 : 0);
            if (i == 9) check_val("byp_word", if_b.parallel_out, 8'hA5);
        end

        // ---------- bypass stream ----------
        obs_b.delete(); obs_bc.delete();
        @(negedge clk);
        idx = 0; k = 0;
        if_b.parallel_in = sw[0];
        if_b.valid_in    = 1'b1;
        while (idx < 4 && k < 100) begin
            acc = if_b.ready_out;
            @(posedge clk);
            if (acc) idx++;
            #1;
            if (idx < 4) if_b.parallel_in = sw[idx];
            else         if_b.valid_in = 1'b0;
            @(negedge clk);
            k++;
        end
        if_b.valid_in = 1'b0;
        check_val("stream_accepts", idx, 4);
        repeat (25) @(negedge clk);
        check_val("stream_count", obs_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < obs_b.size()) begin
                check_val($sformatf("stream_word%0d", i), obs_b[i], sw[i]);
                if (i > 0) check_val($sformatf("stream_gap%0d", i), obs_bc[i] - obs_bc[i-1], 9);
            end
        end

        // ---------- FIFO burst ----------
        obs_f.delete(); obs_fc.delete();
        idx = 0; k = 0; c0 = 0;
        if_f.parallel_in = fw[0];
        if_f.valid_in    = 1'b1;
        while (idx < 6 && k < 60) begin
            acc = if_f.ready_out;
            if (k == 4)  check_val("fifo_full_c4", if_f.fifo_full, 0);
            if (k == 5)  check_val("fifo_full_c5", if_f.fifo_full, 1);
            if (k == 5)  check_val("fifo_ready_c5", if_f.ready_out, 0);
            if (k == 10) check_val("fifo_full_c10", if_f.fifo_full, 1);
            if (k == 11) check_val("fifo_full_c11", if_f.fifo_full, 0);
            if (k == 11) check_val("fifo_ready_c11", if_f.ready_out, 1);
            @(posedge clk);
            if (acc) begin
                acc_k[idx] = k;
                idx++;
            end
            #1;
            if (k == 0) c0 = cyc;
            if (idx < 6) if_f.parallel_in = fw[idx];
            else         if_f.valid_in = 1'b0;
            @(negedge clk);
            if (k == 0) check_val("fifo_empty_c1", if_f.fifo_empty, 0);
            k++;
        end
        if_f.valid_in = 1'b0;
        check_val("fifo_accepts", idx, 6);
        check_val("fifo_acc4", acc_k[4], 4);
        check_val("fifo_acc5_blocked", acc_k[5], 11);

        // ---------- FIFO drain ----------
        k = 0;
        while (obs_f.size() < 6 && k < 120) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check_val("drain_count", obs_f.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs_f.size()) begin
                check_val($sformatf("drain_word%0d", i), obs_f[i], fw[i]);
                if (i > 0) check_val($sformatf("drain_gap%0d", i), obs_fc[i] - obs_fc[i-1], 9);
            end
        end
        if (obs_fc.size() > 0) check_val("drain_first_cyc", obs_fc[0], c0 + 9);
        check_val("drain_empty", if_f.fifo_empty, 1);
        check_val("drain_full", if_f.fifo_full, 0);
        check_val("drain_ready", if_f.ready_out, 1);
        check_val("drain_line", u_fifo.ser_bit, 0);

        // ---------- async reset mid-word ----------
        obs_f.delete(); obs_fc.delete();
        @(negedge clk);
        if_f.parallel_in = 8'h5A;
        if_f.valid_in    = 1'b1;
        @(posedge clk);
        #1 if_f.parallel_in = 8'hC3;
        @(posedge clk);
        #1 if_f.valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("pre_rst_empty", if_f.fifo_empty, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_valid", if_f.valid_out, 0);
        check_val("arst_pout", if_f.parallel_out, 0);
        check_val("arst_ready", if_f.ready_out, 1);
        check_val("arst_empty", if_f.fifo_empty, 1);
        check_val("arst_full", if_f.fifo_full, 0);
        check_val("arst_line", u_fifo.ser_bit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_val("arst_no_output", obs_f.size(), 0);
        if_f.parallel_in = 8'h96;
        if_f.valid_in    = 1'b1;
        @(posedge clk);
        #1 if_f.valid_in = 1'b0;
        k = 0;
        while (obs_f.size() < 1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (12) @(negedge clk);
        check_val("post_rst_count", obs_f.size(), 1);
        if (obs_f.size() > 0) check_val("post_rst_word", obs_f[0], 8'h96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
